// File: rtl/mio_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: address region
// nibbles, FSM state encoding and the region decode helper.
package mio_pkg;

  localparam logic [3:0] NIB_RAM  = 4'h0;
  localparam logic [3:0] NIB_GPIO = 4'hE;
  localparam logic [3:0] NIB_IN   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAM_RD = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_GPIO = 2'd1,
    RGN_IN   = 2'd2,
    RGN_NONE = 2'd3
  } region_t;

  // Map the top address nibble (and GPIO channel index) to a region.
  // GPIO channels that do not exist fall into the unmapped region.
  function automatic region_t decode_region(input logic [3:0] nib,
                                            input logic [3:0] ch,
                                            input int         nch);
    case (nib)
      NIB_RAM:  return RGN_RAM;
      NIB_GPIO: return (int'(ch) < nch) ? RGN_GPIO : RGN_NONE;
      NIB_IN:   return RGN_IN;
      default:  return RGN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mio_bridge_n_sync_2ff.sv
// Generic double-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture chain; first stage may go metastable, second settles.
  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample the pre-edge values and the chain really is two flops deep.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mio_bridge_n.sv
// CPU data-port bridge: decodes accesses into RAM, a bank of GPIO output
// channels and synchronised switch/button inputs, with a req/ready handshake
// (latency 1 for everything except RAM reads, which take 2) and a sticky
// error flag for unmapped accesses.
module mio_bridge_n
  import mio_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int RAM_AW = 10,
  parameter int SW_W   = 16,
  parameter int BTN_W  = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_ready,
  output logic                bus_err,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  output logic                ram_we,
  input  logic [31:0]         ram_rdata,
  output logic [NCH*32-1:0]   gpio_o,
  output logic [NCH-1:0]      gpio_we_o,
  input  logic [SW_W-1:0]     sw_i,
  input  logic [BTN_W-1:0]    btn_i
);

  state_t            state;
  state_t            state_nxt;
  region_t           region;
  logic [3:0]        ch;
  logic              accept;
  logic [31:0]       rd_mux;
  logic [SW_W-1:0]   sw_sync;
  logic [BTN_W-1:0]  btn_sync;
  logic              unused_addr;

  // Only parts of the address are decoded; the rest is intentionally ignored.
  assign unused_addr = ^cpu_addr;

  sync_2ff #(.W(SW_W)) u_sync_sw (
    .clk  (clk),
    .rstn (rstn),
    .d    (sw_i),
    .q    (sw_sync)
  );

  sync_2ff #(.W(BTN_W)) u_sync_btn (
    .clk  (clk),
    .rstn (rstn),
    .d    (btn_i),
    .q    (btn_sync)
  );

  assign ch     = cpu_addr[5:2];
  assign region = decode_region(cpu_addr[31:28], ch, NCH);
  // Strobes are suppressed while reset is asserted so no side effect leaks out.
  assign accept = rstn && (state == ST_IDLE) && cpu_req;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: RAM reads take an extra cycle for the synchronous RAM.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (!cpu_we && region == RGN_RAM) ? ST_RAM_RD : ST_RESP;
        end
      end
      ST_RAM_RD: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: ready pulse in RESP, RAM port driven only in the accept cycle.
  always_comb begin
    cpu_ready = (state == ST_RESP);
    ram_we    = accept && cpu_we && (region == RGN_RAM);
    ram_addr  = accept ? cpu_addr[RAM_AW+1:2] : '0;
    ram_wdata = (accept && cpu_we) ? cpu_wdata : '0;
  end

  // Read data for single-cycle regions; RAM and unmapped reads select zero here.
  always_comb begin
    rd_mux = '0;
    case (region)
      RGN_GPIO: begin
        for (int i = 0; i < NCH; i++) begin
          if (ch == i[3:0]) rd_mux = gpio_o[32*i +: 32];
        end
      end
      RGN_IN: begin
        if (cpu_addr[2]) rd_mux[BTN_W-1:0] = btn_sync;
        else             rd_mux[SW_W-1:0]  = sw_sync;
      end
      default: rd_mux = '0;
    endcase
  end

  // Response data and sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
    end else if (accept) begin
      if (region == RGN_NONE) bus_err <= 1'b1;
      cpu_rdata <= cpu_we ? 32'd0 : rd_mux;
    end else if (state == ST_RAM_RD) begin
      cpu_rdata <= ram_rdata;
    end
  end

  // GPIO output channel bank, one register per channel.
  for (genvar g = 0; g < NCH; g++) begin : g_gpio
    logic        hit;
    logic [31:0] chan_q;

    assign hit = accept && cpu_we && (region == RGN_GPIO) && (ch == 4'(g));
    assign gpio_we_o[g]        = hit;
    assign gpio_o[32*g +: 32]  = chan_q;

    // Channel register: loads write data in the accept cycle.
    // NOTE: this bank drives pins directly, so unlike a RAM array it is
    // reset to a known value.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)    chan_q <= '0;
      else if (hit) chan_q <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_mio_bridge_n.sv
// Self-checking bench for mio_bridge_n: directed vector table, hand-written
// multi-cycle sequences and randomized accesses against a behavioural model.
module tb_mio_bridge_n;

  localparam int NCH    = 4;
  localparam int RAM_AW = 10;
  localparam int SW_W   = 16;
  localparam int BTN_W  = 5;

  logic                clk;
  logic                rstn;
  logic                cpu_req;
  logic                cpu_we;
  logic [31:0]         cpu_addr;
  logic [31:0]         cpu_wdata;
  logic [31:0]         cpu_rdata;
  logic                cpu_ready;
  logic                bus_err;
  logic [RAM_AW-1:0]   ram_addr;
  logic [31:0]         ram_wdata;
  logic                ram_we;
  logic [31:0]         ram_rdata;
  logic [NCH*32-1:0]   gpio_o;
  logic [NCH-1:0]      gpio_we_o;
  logic [SW_W-1:0]     sw_i;
  logic [BTN_W-1:0]    btn_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment RAM and reference model state.
  logic [31:0] ram_mem  [1 << RAM_AW];
  logic [31:0] ref_mem  [1 << RAM_AW];
  logic [31:0] ref_gpio [NCH];
  logic        ref_err;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  mio_bridge_n #(
    .NCH(NCH), .RAM_AW(RAM_AW), .SW_W(SW_W), .BTN_W(BTN_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .bus_err   (bus_err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .gpio_o    (gpio_o),
    .gpio_we_o (gpio_we_o),
    .sw_i      (sw_i),
    .btn_i     (btn_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM block seen by the bridge.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0 = RAM, 1 = GPIO, 2 = inputs, 3 = unmapped
  function automatic int rgn_of(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 0;
      4'hE:    return (int'(a[5:2]) < NCH) ? 1 : 3;
      4'hF:    return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (rgn_of(a))
      0:       return ref_mem[int'(a[RAM_AW+1:2])];
      1:       return ref_gpio[int'(a[5:2])];
      2:       return a[2] ? {27'd0, btn_i} : {16'd0, sw_i};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] d);
    int r;
    r = rgn_of(a);
    if (r == 3) ref_err = 1'b1;
    if (we && r == 0) ref_mem[int'(a[RAM_AW+1:2])] = d;
    if (we && r == 1) ref_gpio[int'(a[5:2])] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) ref_gpio[i] = 32'd0;
    ref_err = 1'b0;
  endtask

  task automatic check_gpio(input string tag);
    for (int i = 0; i < NCH; i++)
      check($sformatf("%s gpio ch%0d", tag, i), gpio_o[32*i +: 32], ref_gpio[i]);
  endtask

  // One complete access; entered and left at posedge+1 with the bridge idle.
  task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rdata, output int lat);
    int          r;
    logic [31:0] exp_gwe;
    r       = rgn_of(a);
    exp_gwe = (we && r == 1) ? (32'd1 << a[5:2]) : 32'd0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    check("accept gpio_we", 32'(gpio_we_o), exp_gwe);
    check("accept ram_we", 32'(ram_we), 32'(we && r == 0));
    check("accept ready", 32'(cpu_ready), 32'd0);
    if (r == 0) begin
      check("accept ram_addr", 32'(ram_addr), 32'(a[RAM_AW+1:2]));
      if (we) check("accept ram_wdata", ram_wdata, d);
    end
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      lat = c;
      check("strobes after accept", {gpio_we_o, ram_we}, '0);
      if (cpu_ready) break;
    end
    if (!cpu_ready) check("ready timeout", 32'(cpu_ready), 32'd1);
    rdata   = cpu_rdata;
    cpu_req = 1'b0;
    model_access(we, a, d);
    @(posedge clk); #1;
    check("ready one cycle", 32'(cpu_ready), 32'd0);
    check_gpio("post");
  endtask

  task automatic settle_inputs(input logic [SW_W-1:0] s, input logic [BTN_W-1:0] b);
    sw_i = s; btn_i = b;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [31:0] bb_addr [3];
    logic [31:0] bb_data [3];
    int          ready_cyc[$];
    int          k;

    vecs[0]  = '{1'b1, 32'hE000_0008, 32'h1234_5678, 32'h0,          1, 1'b0};
    vecs[1]  = '{1'b0, 32'hE000_0008, 32'h0,         32'h1234_5678, 1, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,          1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 2, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_1013, 32'h0,         32'hCAFE_F00D, 2, 1'b0};
    vecs[5]  = '{1'b0, 32'hF000_0000, 32'h0,         32'h0000_A5A5, 1, 1'b0};
    vecs[6]  = '{1'b0, 32'hF000_0004, 32'h0,         32'h0000_0011, 1, 1'b0};
    vecs[7]  = '{1'b0, 32'hE000_0010, 32'h0,         32'h0,          1, 1'b1};
    vecs[8]  = '{1'b0, 32'hE000_0008, 32'h0,         32'h1234_5678, 1, 1'b1};
    vecs[9]  = '{1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 32'h0,          1, 1'b1};
    vecs[10] = '{1'b0, 32'hE000_0000, 32'h0,         32'h0,          1, 1'b1};

    for (int i = 0; i < (1 << RAM_AW); i++) begin
      ram_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
      ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
    end
    model_reset();

    rstn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    sw_i = '0; btn_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cpu_ready", 32'(cpu_ready), 32'd0);
    check("reset cpu_rdata", cpu_rdata, 32'd0);
    check("reset bus_err", 32'(bus_err), 32'd0);
    check("reset gpio_we", 32'(gpio_we_o), 32'd0);
    check("reset ram_we", 32'(ram_we), 32'd0);
    check_gpio("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    settle_inputs(16'hA5A5, 5'h11);
    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      if (!vecs[i].we) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d bus_err", i), 32'(bus_err), 32'(vecs[i].exp_err));
    end

    // Request fields changing while busy are ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_wdata = '0;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 32'hE000_0000; cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("busy gpio_we", 32'(gpio_we_o), 32'd0);
    check("busy ready early", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    check("busy ready", 32'(cpu_ready), 32'd1);
    check("busy rdata", cpu_rdata, 32'hCAFE_F00D);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check_gpio("busy");

    // Reset while a RAM read is in flight
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    @(posedge clk); #1;
    rstn = 1'b0; cpu_req = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("abort cpu_ready", 32'(cpu_ready), 32'd0);
      check("abort cpu_rdata", cpu_rdata, 32'd0);
      check("abort bus_err", 32'(bus_err), 32'd0);
      check("abort strobes", {gpio_we_o, ram_we}, '0);
      check("abort ram_addr", 32'(ram_addr), 32'd0);
      check_gpio("abort");
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    settle_inputs(16'hA5A5, 5'h11);
    do_access(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    check("post-abort rdata", rd, 32'hCAFE_F00D);
    check("post-abort latency", 32'(lat), 32'd2);

    // Back-to-back GPIO writes with req held high
    bb_addr[0] = 32'hE000_0000; bb_data[0] = 32'h1111_0000;
    bb_addr[1] = 32'hE000_0004; bb_data[1] = 32'h2222_0001;
    bb_addr[2] = 32'hE000_000C; bb_data[2] = 32'h3333_0003;
    k = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = bb_addr[0]; cpu_wdata = bb_data[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cpu_ready) begin
        ready_cyc.push_back(c);
        if (k < 3) model_access(1'b1, bb_addr[k], bb_data[k]);
        k++;
        if (k < 3) begin
          cpu_addr = bb_addr[k]; cpu_wdata = bb_data[k];
        end else begin
          cpu_req = 1'b0;
        end
      end
    end
    check("b2b ready count", 32'(ready_cyc.size()), 32'd3);
    if (ready_cyc.size() == 3) begin
      check("b2b first ready", 32'(ready_cyc[0]), 32'd1);
      check("b2b spacing 1", 32'(ready_cyc[1] - ready_cyc[0]), 32'd2);
      check("b2b spacing 2", 32'(ready_cyc[2] - ready_cyc[1]), 32'd2);
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check_gpio("b2b");

    // Randomized accesses against the model
    for (int it = 0; it < 80; it++) begin
      logic [31:0] a;
      logic        we;
      logic [31:0] d;
      logic [31:0] exp;
      int          kind;
      if (it % 10 == 0) settle_inputs(SW_W'($urandom), BTN_W'($urandom));
      a    = $urandom;
      d    = $urandom;
      we   = 1'($urandom);
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin a[31:28] = 4'h0; a[11:2] = 10'($urandom_range(0, 15)); end
        1: begin a[31:28] = 4'hE; a[5:2] = 4'($urandom_range(0, 7)); end
        2: a[31:28] = 4'hF;
        default: a[31:28] = 4'($urandom_range(1, 13));
      endcase
      exp = model_read(a);
      do_access(we, a, d, rd, lat);
      if (!we) check($sformatf("rand%0d rdata @%h", it, a), rd, exp);
      check($sformatf("rand%0d latency @%h", it, a), 32'(lat),
            32'((!we && rgn_of(a) == 0) ? 2 : 1));
      check($sformatf("rand%0d bus_err", it), 32'(bus_err), 32'(ref_err));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
